// File: rtl/sb_rd_arbiter_if.sv
// System-bus read channel: address request plus read-data return.
interface sb_rd_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;

    // Initiator side of the channel
    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata
    );

    // Target side of the channel
    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata
    );
endinterface

// File: rtl/sb_rd_arbiter.sv
// 2:1 system-bus read arbiter: instruction fetch (m0) and load/store (m1)
// share one slave read port, one outstanding read at a time.
module sb_rd_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter bit          PRIO_FIXED = 1'b0
) (
    input  logic   sb_clk,
    input  logic   sb_rst,
    sb_rd_if.slave  m0,
    sb_rd_if.slave  m1,
    sb_rd_if.master s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant;
    logic              grant_nxt;
    logic              last;
    logic              last_nxt;
    logic              rready_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] rdata_c;

    // State, grant and last-served registers; last=1 so m0 wins the first tie.
    always_ff @(posedge sb_clk) begin
        if (sb_rst) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    // Address and data steering follow the held grant.
    assign addr_c   = grant ? m1.araddr : m0.araddr;
    assign rready_c = grant ? m1.rready : m0.rready;
    assign rdata_c  = s.rdata;
    assign s.araddr = addr_c;
    assign m0.rdata = rdata_c;
    assign m1.rdata = rdata_c;

    // Next-state, grant selection and handshake routing.
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        last_nxt   = last;
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m1.rvalid  = 1'b0;
        case (state)
            IDLE: begin
                if (m0.arvalid || m1.arvalid) begin
                    if (m0.arvalid && m1.arvalid) begin
                        grant_nxt = PRIO_FIXED ? 1'b0 : ~last;
                    end else begin
                        grant_nxt = m1.arvalid;
                    end
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                s.arvalid = 1'b1;
                if (grant) begin
                    m1.arready = s.arready;
                end else begin
                    m0.arready = s.arready;
                end
                if (s.arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                s.rready = rready_c;
                if (grant) begin
                    m1.rvalid = s.rvalid;
                end else begin
                    m0.rvalid = s.rvalid;
                end
                if (s.rvalid && rready_c) begin
                    last_nxt  = grant;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sb_rd_arbiter.sv
// Directed bench for sb_rd_arbiter: cycle vector table on a round-robin
// instance plus a fixed-priority sequence on a second instance.
module tb_sb_rd_arbiter;

    logic sb_clk;
    logic sb_rst;
    int   checks;
    int   errors;

    sb_rd_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    sb_rd_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    sb_rd_if #(.ADDR_W(32), .DATA_W(32)) s_if ();
    sb_rd_if #(.ADDR_W(32), .DATA_W(32)) p_m0 ();
    sb_rd_if #(.ADDR_W(32), .DATA_W(32)) p_m1 ();
    sb_rd_if #(.ADDR_W(32), .DATA_W(32)) p_s ();

    sb_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_FIXED(1'b0)) dut (
        .sb_clk (sb_clk),
        .sb_rst (sb_rst),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if)
    );

    sb_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_FIXED(1'b1)) dut_p (
        .sb_clk (sb_clk),
        .sb_rst (sb_rst),
        .m0     (p_m0),
        .m1     (p_m1),
        .s      (p_s)
    );

    // 10 ns clock
    initial begin
        sb_clk = 1'b0;
        forever #5 sb_clk = ~sb_clk;
    end

    // in_f  = {rst, m0_arvalid, m0_rready, m1_arvalid, m1_rready, s_arready, s_rvalid}
    // ex_f  = {s_arvalid, s_rready, m0_arready, m0_rvalid, m1_arready, m1_rvalid}
    // sa    = expected s_araddr, compared only when s_arvalid is expected
    typedef struct {
        logic [6:0]  in_f;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] sd;
        logic [5:0]  ex_f;
        logic [31:0] sa;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [6:0] in_f, input logic [31:0] a0,
                       input logic [31:0] a1, input logic [31:0] sd,
                       input logic [5:0] ex_f, input logic [31:0] sa);
        vec_t v;
        v.in_f = in_f;
        v.a0   = a0;
        v.a1   = a1;
        v.sd   = sd;
        v.ex_f = ex_f;
        v.sa   = sa;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic ok,
                         input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        logic [5:0] got_f;
        int         grants;
        checks = 0;
        errors = 0;
        sb_rst = 1'b1;
        m0_if.arvalid = 1'b0; m0_if.araddr = '0; m0_if.rready = 1'b0;
        m1_if.arvalid = 1'b0; m1_if.araddr = '0; m1_if.rready = 1'b0;
        s_if.arready  = 1'b0; s_if.rvalid  = 1'b0; s_if.rdata  = '0;
        p_m0.arvalid  = 1'b0; p_m0.araddr  = '0; p_m0.rready  = 1'b0;
        p_m1.arvalid  = 1'b0; p_m1.araddr  = '0; p_m1.rready  = 1'b0;
        p_s.arready   = 1'b0; p_s.rvalid   = 1'b0; p_s.rdata   = '0;

        // Single m0 read, 1-cycle slave: rvalid on cycle 2
        add(7'b0000000, 32'h0,   32'h0, 32'h0,        6'b000000, 32'h0);
        add(7'b0100000, 32'h100, 32'h0, 32'h0,        6'b000000, 32'h0);
        add(7'b0100010, 32'h100, 32'h0, 32'h0,        6'b101000, 32'h100);
        add(7'b0010001, 32'h100, 32'h0, 32'hDEADBEEF, 6'b010100, 32'h0);
        add(7'b0000000, 32'h0,   32'h0, 32'h0,        6'b000000, 32'h0);
        // Reset, then continuous tie in round-robin: 10,20,10,20
        add(7'b1000000, 32'h0,   32'h0,  32'h0,       6'b000000, 32'h0);
        add(7'b0111100, 32'h10,  32'h20, 32'h0,       6'b000000, 32'h0);
        add(7'b0111110, 32'h10,  32'h20, 32'h0,       6'b101000, 32'h10);
        add(7'b0111101, 32'h10,  32'h20, 32'hA0,      6'b010100, 32'h0);
        add(7'b0111100, 32'h10,  32'h20, 32'h0,       6'b000000, 32'h0);
        add(7'b0111110, 32'h10,  32'h20, 32'h0,       6'b100010, 32'h20);
        add(7'b0111101, 32'h10,  32'h20, 32'hA1,      6'b010001, 32'h0);
        add(7'b0111100, 32'h10,  32'h20, 32'h0,       6'b000000, 32'h0);
        add(7'b0111111, 32'h10,  32'h20, 32'hBAD,     6'b101000, 32'h10);
        add(7'b0111101, 32'h10,  32'h20, 32'hA2,      6'b010100, 32'h0);
        add(7'b0111100, 32'h10,  32'h20, 32'h0,       6'b000000, 32'h0);
        add(7'b0111110, 32'h10,  32'h20, 32'h0,       6'b100010, 32'h20);
        add(7'b0111101, 32'h10,  32'h20, 32'hA3,      6'b010001, 32'h0);
        // m0 stalls rready 3 cycles while m1 waits
        add(7'b0100000, 32'h30,  32'h0,  32'h0,       6'b000000, 32'h0);
        add(7'b0100010, 32'h30,  32'h0,  32'h0,       6'b101000, 32'h30);
        add(7'b0001001, 32'h30,  32'h40, 32'hB0,      6'b000100, 32'h0);
        add(7'b0001001, 32'h30,  32'h40, 32'hB0,      6'b000100, 32'h0);
        add(7'b0001001, 32'h30,  32'h40, 32'hB0,      6'b000100, 32'h0);
        add(7'b0011001, 32'h30,  32'h40, 32'hB0,      6'b010100, 32'h0);
        add(7'b0001000, 32'h0,   32'h40, 32'h0,       6'b000000, 32'h0);
        add(7'b0001010, 32'h0,   32'h40, 32'h0,       6'b100010, 32'h40);
        // Reset during m1 DATA, then a tie goes to m0
        add(7'b1000001, 32'h0,   32'h0,  32'hC0,      6'b000001, 32'h0);
        add(7'b0111101, 32'h50,  32'h60, 32'hC0,      6'b000000, 32'h0);
        add(7'b0111110, 32'h50,  32'h60, 32'h0,       6'b101000, 32'h50);
        add(7'b0111101, 32'h50,  32'h60, 32'hC1,      6'b010100, 32'h0);
        // Slave holds off arready for 2 cycles
        add(7'b0100000, 32'h70,  32'h0,  32'h0,       6'b000000, 32'h0);
        add(7'b0100000, 32'h70,  32'h0,  32'h0,       6'b100000, 32'h70);
        add(7'b0100000, 32'h70,  32'h0,  32'h0,       6'b100000, 32'h70);
        add(7'b0100010, 32'h70,  32'h0,  32'h0,       6'b101000, 32'h70);
        add(7'b0010001, 32'h0,   32'h0,  32'hD0,      6'b010100, 32'h0);
        add(7'b0000000, 32'h0,   32'h0,  32'h0,       6'b000000, 32'h0);

        repeat (2) @(posedge sb_clk);

        // Apply each vector on the falling edge, compare 1 ns later
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge sb_clk);
            sb_rst        = vecs[i].in_f[6];
            m0_if.arvalid = vecs[i].in_f[5];
            m0_if.rready  = vecs[i].in_f[4];
            m1_if.arvalid = vecs[i].in_f[3];
            m1_if.rready  = vecs[i].in_f[2];
            s_if.arready  = vecs[i].in_f[1];
            s_if.rvalid   = vecs[i].in_f[0];
            m0_if.araddr  = vecs[i].a0;
            m1_if.araddr  = vecs[i].a1;
            s_if.rdata    = vecs[i].sd;
            #1;
            got_f = {s_if.arvalid, s_if.rready, m0_if.arready, m0_if.rvalid,
                     m1_if.arready, m1_if.rvalid};
            check($sformatf("vec%0d_ctl_addr", i),
                  (got_f == vecs[i].ex_f) && (!vecs[i].ex_f[5] || s_if.araddr == vecs[i].sa),
                  {26'h0, got_f, s_if.araddr}, {26'h0, vecs[i].ex_f, vecs[i].sa});
            check($sformatf("vec%0d_rdata", i),
                  (m0_if.rdata == vecs[i].sd) && (m1_if.rdata == vecs[i].sd),
                  {m0_if.rdata, m1_if.rdata}, {vecs[i].sd, vecs[i].sd});
        end

        // Fixed priority: both masters request forever, m0 takes every grant
        @(negedge sb_clk);
        sb_rst       = 1'b0;
        p_m0.arvalid = 1'b1; p_m0.araddr = 32'h10; p_m0.rready = 1'b1;
        p_m1.arvalid = 1'b1; p_m1.araddr = 32'h20; p_m1.rready = 1'b1;
        p_s.arready  = 1'b1; p_s.rvalid  = 1'b1;  p_s.rdata   = 32'h5;
        grants = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("prio_m1_quiet_c%0d", c),
                  (p_m1.arready == 1'b0) && (p_m1.rvalid == 1'b0),
                  {62'h0, p_m1.arready, p_m1.rvalid}, 64'h0);
            if (p_s.arvalid && p_s.arready) begin
                grants++;
                check($sformatf("prio_addr_c%0d", c),
                      (p_s.araddr == 32'h10) && (p_m0.arready == 1'b1),
                      {31'h0, p_m0.arready, p_s.araddr}, {31'h0, 1'b1, 32'h10});
            end
            @(negedge sb_clk);
        end
        check("prio_grant_count", grants == 4, 64'(grants), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
